// File: rtl/mux_n_skid_stage_pkg.sv
// ---------------------------------------------------------------------------
// mux_n_skid_stage_pkg
// Shared definitions for the N-way operand select skid stage:
//   - state_t   : occupancy state of the two-entry output stage
//   - OCC_W     : width of the occupancy count output
//   - clog2     : ceiling log2 helper used to size select buses
// ---------------------------------------------------------------------------
package mux_n_skid_stage_pkg;

    // The stage is never more than two entries deep, so 2 bits cover 0..2.
    localparam int OCC_W = 2;

    // EMPTY: nothing held; ONE: main register valid; TWO: main and skid valid.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    // Ceiling log2; returns 0 for values of 0 or 1, so callers that need a
    // usable bus width clamp the result to at least 1.
    function automatic int clog2(input int value);
        int result;
        int remaining;
        result    = 0;
        remaining = value - 1;
        while (remaining > 0) begin
            result    = result + 1;
            remaining = remaining >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/mux_n_skid_stage_mux_n.sv
// ---------------------------------------------------------------------------
// mux_n
// Combinational N-way, WIDTH-bit select with a fallback value for select
// codes that do not name an input.
// Ports:
//   i_data  : NUM_IN*WIDTH packed inputs, input k at [k*WIDTH +: WIDTH]
//   i_sel   : SEL_W-bit input index
//   o_data  : selected input, or DEFAULT_VAL when i_sel >= NUM_IN
//   o_err   : high when i_sel >= NUM_IN
// ---------------------------------------------------------------------------
module mux_n
    import mux_n_skid_stage_pkg::*;
#(
    parameter int               WIDTH       = 32,
    parameter int               NUM_IN      = 3,
    parameter int               SEL_W       = (clog2(NUM_IN) < 1) ? 1 : clog2(NUM_IN),
    parameter logic [WIDTH-1:0] DEFAULT_VAL = '0
) (
    input  logic [NUM_IN*WIDTH-1:0] i_data,
    input  logic [SEL_W-1:0]        i_sel,
    output logic [WIDTH-1:0]        o_data,
    output logic                    o_err
);

    // Start from the out-of-range result and let a matching index override
    // it; comparing against each constant index keeps every part-select in
    // bounds, even for select codes beyond NUM_IN-1.
    always_comb begin
        o_data = DEFAULT_VAL;
        o_err  = 1'b1;
        for (int k = 0; k < NUM_IN; k++) begin
            if (i_sel == SEL_W'(k)) begin
                o_data = i_data[k*WIDTH +: WIDTH];
                o_err  = 1'b0;
            end
        end
    end

endmodule

// File: rtl/mux_n_skid_stage.sv
// ---------------------------------------------------------------------------
// mux_n_skid_stage
// N-way operand select feeding a registered valid/ready output stage with a
// two-entry skid buffer, so upstream sees full throughput under backpressure.
// Ports:
//   clk       : rising-edge clock
//   reset     : asynchronous active-low reset
//   in_data   : NUM_IN*WIDTH packed inputs
//   in_sel    : input select
//   in_valid  : upstream offers a transfer
//   in_ready  : stage can accept (registered)
//   flush     : synchronous discard of held and incoming data
//   out_data  : head entry, registered
//   out_valid : out_data holds a valid entry
//   out_ready : downstream accepts
//   sel_err   : sticky flag, an accepted transfer used an out-of-range select
//   occupancy : number of entries held (0..2)
// ---------------------------------------------------------------------------
module mux_n_skid_stage
    import mux_n_skid_stage_pkg::*;
#(
    parameter int               WIDTH       = 32,
    parameter int               NUM_IN      = 3,
    parameter int               SEL_W       = (clog2(NUM_IN) < 1) ? 1 : clog2(NUM_IN),
    parameter logic [WIDTH-1:0] DEFAULT_VAL = '0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]        in_sel,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    flush,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    sel_err,
    output logic [OCC_W-1:0]        occupancy
);

    state_t           r_state;
    state_t           w_next_state;
    logic [WIDTH-1:0] r_main;
    logic [WIDTH-1:0] r_skid;
    logic             r_in_ready;
    logic             r_sel_err;
    logic [WIDTH-1:0] w_selected;
    logic             w_range_err;
    logic             w_accept;
    logic             w_fire;
    logic             w_load_main_sel;
    logic             w_load_skid;
    logic             w_main_from_skid;

    // Operand selection happens before the registers so the stored value is
    // already the chosen operand.
    mux_n #(
        .WIDTH       (WIDTH),
        .NUM_IN      (NUM_IN),
        .SEL_W       (SEL_W),
        .DEFAULT_VAL (DEFAULT_VAL)
    ) u_mux_n (
        .i_data (in_data),
        .i_sel  (in_sel),
        .o_data (w_selected),
        .o_err  (w_range_err)
    );

    assign w_accept = in_valid & r_in_ready;
    assign w_fire   = out_valid & out_ready;

    // Which register captures what this cycle: a new entry goes straight to
    // main when main is free or draining, otherwise it parks in skid; when
    // both are full and the head leaves, skid moves up into main.
    assign w_load_main_sel  = w_accept & ((r_state == ST_EMPTY) | ((r_state == ST_ONE) & w_fire));
    assign w_load_skid      = w_accept & (r_state == ST_ONE) & ~w_fire;
    assign w_main_from_skid = (r_state == ST_TWO) & w_fire;

    // State register; reset leaves the stage empty.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; flush overrides every handshake and empties the stage.
    always_comb begin
        w_next_state = r_state;
        if (flush) begin
            w_next_state = ST_EMPTY;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_accept) begin
                        w_next_state = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (w_accept && !w_fire) begin
                        w_next_state = ST_TWO;
                    end else if (!w_accept && w_fire) begin
                        w_next_state = ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    if (w_fire) begin
                        w_next_state = ST_ONE;
                    end
                end
                default: begin
                    w_next_state = ST_EMPTY;
                end
            endcase
        end
    end

    // Output decode straight from the state register, so out_valid and
    // occupancy are glitch-free registered values.
    always_comb begin
        out_valid = (r_state != ST_EMPTY);
        case (r_state)
            ST_ONE:  occupancy = OCC_W'(1);
            ST_TWO:  occupancy = OCC_W'(2);
            default: occupancy = OCC_W'(0);
        endcase
        in_ready = r_in_ready;
        out_data = r_main;
        sel_err  = r_sel_err;
    end

    // in_ready is registered from the next state: it stays low out of reset
    // until the first edge, and drops whenever the stage will be full.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_in_ready <= 1'b0;
        end else begin
            r_in_ready <= (w_next_state != ST_TWO);
        end
    end

    // Data registers; flush clears them so stale operands never linger.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_main <= '0;
            r_skid <= '0;
        end else if (flush) begin
            r_main <= '0;
            r_skid <= '0;
        end else begin
            if (w_load_main_sel) begin
                r_main <= w_selected;
            end else if (w_main_from_skid) begin
                r_main <= r_skid;
            end
            if (w_load_skid) begin
                r_skid <= w_selected;
            end
        end
    end

    // Sticky select-range error; only transfers that are really kept count,
    // so an accept discarded by flush does not set it, and flush never
    // clears it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sel_err <= 1'b0;
        end else if (w_accept && w_range_err && !flush) begin
            r_sel_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mux_n_skid_stage.sv
module tb_mux_n_skid_stage;

    localparam int W  = 32;
    localparam int N  = 3;
    localparam int SW = 2;
    localparam int VW = 8;
    localparam int VN = 5;
    localparam int VS = 3;

    logic            clk = 1'b0;
    logic            rstN;
    logic [N*W-1:0]  inData;
    logic [SW-1:0]   inSel;
    logic            inValid;
    logic            inReady;
    logic            flush;
    logic [W-1:0]    outData;
    logic            outValid;
    logic            outReady;
    logic            selErr;
    logic [1:0]      occupancy;

    logic [VN*VW-1:0] vData;
    logic [VS-1:0]    vSel;
    logic             vValid;
    logic             vInReady;
    logic [VW-1:0]    vOutData;
    logic             vOutValid;
    logic             vSelErr;
    logic [1:0]       vOccupancy;

    int total = 0;
    int bad   = 0;

    logic [W-1:0] modelQ[$];
    bit           modelErr;
    bit           modelReady;

    // Free-running clock, 10 time units per period.
    always #5 clk = ~clk;

    mux_n_skid_stage #(.WIDTH(W), .NUM_IN(N)) dut (
        .clk       (clk),
        .reset     (rstN),
        .in_data   (inData),
        .in_sel    (inSel),
        .in_valid  (inValid),
        .in_ready  (inReady),
        .flush     (flush),
        .out_data  (outData),
        .out_valid (outValid),
        .out_ready (outReady),
        .sel_err   (selErr),
        .occupancy (occupancy)
    );

    mux_n_skid_stage #(.WIDTH(VW), .NUM_IN(VN), .DEFAULT_VAL(8'hEE)) dutVar (
        .clk       (clk),
        .reset     (rstN),
        .in_data   (vData),
        .in_sel    (vSel),
        .in_valid  (vValid),
        .in_ready  (vInReady),
        .flush     (1'b0),
        .out_data  (vOutData),
        .out_valid (vOutValid),
        .out_ready (1'b1),
        .sel_err   (vSelErr),
        .occupancy (vOccupancy)
    );

    // Reference select: named input, or zero for codes past the last input.
    function automatic logic [W-1:0] refSelect(input logic [N*W-1:0] d, input int s);
        if (s < N) return d[s*W +: W];
        return '0;
    endfunction

    // One clock edge of the reference model: a FIFO of at most two entries.
    task automatic cycle();
        bit acc;
        bit fire;
        @(posedge clk);
        acc  = inValid && modelReady;
        fire = (modelQ.size() > 0) && outReady;
        if (flush) begin
            modelQ.delete();
        end else begin
            if (fire) void'(modelQ.pop_front());
            if (acc) begin
                modelQ.push_back(refSelect(inData, int'(inSel)));
                if (int'(inSel) >= N) modelErr = 1'b1;
            end
        end
        modelReady = (modelQ.size() < 2);
        #1;
    endtask

    task automatic applyStimulus(input bit v, input int s, input bit r, input bit f);
        inValid  = v;
        inSel    = SW'(s);
        outReady = r;
        flush    = f;
    endtask

    task automatic test_reset();
        rstN = 1'b0;
        applyStimulus(0, 0, 1, 0);
        vValid = 1'b0;
        vSel   = '0;
        vData  = '0;
        inData = {32'h33333333, 32'h22222222, 32'h11111111};
        modelQ.delete();
        modelErr   = 1'b0;
        modelReady = 1'b0;
        #12;
        total++;
        if ({outValid, inReady, selErr, occupancy} !== 5'b0) begin
            bad++;
            $display("[TB] FAIL reset_ctrl: got %b expected 00000", {outValid, inReady, selErr, occupancy});
        end
        total++;
        if (outData !== 32'h0) begin
            bad++;
            $display("[TB] FAIL reset_data: got %h expected 00000000", outData);
        end
        @(negedge clk);
        rstN = 1'b1;
        cycle();
        total++;
        if (inReady !== 1'b1) begin
            bad++;
            $display("[TB] FAIL reset_release_ready: got %b expected 1", inReady);
        end
    endtask

    task automatic test_select_sweep();
        logic [W-1:0] expVals[3];
        expVals[0] = 32'h11111111;
        expVals[1] = 32'h22222222;
        expVals[2] = 32'h33333333;
        for (int s = 0; s < 3; s++) begin
            applyStimulus(1, s, 1, 0);
            cycle();
            total++;
            if (outValid !== 1'b1 || outData !== expVals[s] || occupancy !== 2'd1) begin
                bad++;
                $display("[TB] FAIL sweep_sel%0d: got v=%b d=%h occ=%0d expected v=1 d=%h occ=1",
                         s, outValid, outData, occupancy, expVals[s]);
            end
        end
        applyStimulus(0, 0, 1, 0);
        cycle();
        total++;
        if (outValid !== 1'b0 || occupancy !== 2'd0) begin
            bad++;
            $display("[TB] FAIL sweep_drain: got v=%b occ=%0d expected v=0 occ=0", outValid, occupancy);
        end
    endtask

    task automatic test_flush();
        applyStimulus(1, 0, 0, 0);
        cycle();
        applyStimulus(1, 1, 0, 0);
        cycle();
        total++;
        if (occupancy !== 2'd2 || inReady !== 1'b0) begin
            bad++;
            $display("[TB] FAIL flush_fill: got occ=%0d rdy=%b expected occ=2 rdy=0", occupancy, inReady);
        end
        applyStimulus(1, 3, 0, 1);
        cycle();
        total++;
        if (outValid !== 1'b0 || occupancy !== 2'd0 || inReady !== 1'b1 || selErr !== 1'b0) begin
            bad++;
            $display("[TB] FAIL flush_state: got v=%b occ=%0d rdy=%b err=%b expected v=0 occ=0 rdy=1 err=0",
                     outValid, occupancy, inReady, selErr);
        end
        applyStimulus(0, 0, 1, 0);
        cycle();
        total++;
        if (outValid !== 1'b0) begin
            bad++;
            $display("[TB] FAIL flush_no_reappear: got v=%b expected 0", outValid);
        end
    endtask

    task automatic test_out_of_range();
        applyStimulus(1, 3, 1, 0);
        cycle();
        total++;
        if (outValid !== 1'b1 || outData !== 32'h0 || selErr !== 1'b1) begin
            bad++;
            $display("[TB] FAIL oor_select: got v=%b d=%h err=%b expected v=1 d=00000000 err=1",
                     outValid, outData, selErr);
        end
        applyStimulus(1, 0, 1, 0);
        cycle();
        total++;
        if (outData !== 32'h11111111 || selErr !== 1'b1) begin
            bad++;
            $display("[TB] FAIL oor_sticky: got d=%h err=%b expected d=11111111 err=1", outData, selErr);
        end
        applyStimulus(0, 0, 1, 0);
        cycle();
    endtask

    task automatic test_back_to_back();
        applyStimulus(1, 0, 0, 0);
        cycle();
        total++;
        if (occupancy !== 2'd1 || inReady !== 1'b1 || outData !== 32'h11111111) begin
            bad++;
            $display("[TB] FAIL bp_a: got occ=%0d rdy=%b d=%h expected occ=1 rdy=1 d=11111111",
                     occupancy, inReady, outData);
        end
        applyStimulus(1, 1, 0, 0);
        cycle();
        applyStimulus(1, 2, 0, 0);
        cycle();
        total++;
        if (occupancy !== 2'd2 || inReady !== 1'b0 || outData !== 32'h11111111) begin
            bad++;
            $display("[TB] FAIL bp_stall: got occ=%0d rdy=%b d=%h expected occ=2 rdy=0 d=11111111",
                     occupancy, inReady, outData);
        end
        applyStimulus(1, 2, 1, 0);
        cycle();
        total++;
        if (occupancy !== 2'd1 || inReady !== 1'b1 || outData !== 32'h22222222) begin
            bad++;
            $display("[TB] FAIL bp_release_b: got occ=%0d rdy=%b d=%h expected occ=1 rdy=1 d=22222222",
                     occupancy, inReady, outData);
        end
        cycle();
        total++;
        if (occupancy !== 2'd1 || outValid !== 1'b1 || outData !== 32'h33333333) begin
            bad++;
            $display("[TB] FAIL bp_release_c: got occ=%0d v=%b d=%h expected occ=1 v=1 d=33333333",
                     occupancy, outValid, outData);
        end
        applyStimulus(0, 0, 1, 0);
        cycle();
        total++;
        if (outValid !== 1'b0 || occupancy !== 2'd0) begin
            bad++;
            $display("[TB] FAIL bp_empty: got v=%b occ=%0d expected v=0 occ=0", outValid, occupancy);
        end
    endtask

    task automatic test_async_reset();
        applyStimulus(1, 0, 0, 0);
        cycle();
        applyStimulus(1, 1, 0, 0);
        cycle();
        #3;
        rstN = 1'b0;
        modelQ.delete();
        modelErr   = 1'b0;
        modelReady = 1'b0;
        #1;
        total++;
        if ({outValid, inReady, selErr, occupancy} !== 5'b0 || outData !== 32'h0) begin
            bad++;
            $display("[TB] FAIL async_reset: got v=%b rdy=%b err=%b occ=%0d d=%h expected all zero",
                     outValid, inReady, selErr, occupancy, outData);
        end
        applyStimulus(0, 0, 1, 0);
        @(negedge clk);
        rstN = 1'b1;
        cycle();
        total++;
        if (inReady !== 1'b1 || outValid !== 1'b0) begin
            bad++;
            $display("[TB] FAIL async_release: got rdy=%b v=%b expected rdy=1 v=0", inReady, outValid);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            inData = {$urandom, $urandom, $urandom};
            applyStimulus(bit'($urandom_range(0, 3) != 0), int'($urandom_range(0, 3)),
                          bit'($urandom_range(0, 2) != 0), bit'($urandom_range(0, 15) == 0));
            cycle();
            total++;
            if (outValid !== (modelQ.size() > 0) || occupancy !== 2'(modelQ.size())
                || inReady !== modelReady || selErr !== modelErr) begin
                bad++;
                $display("[TB] FAIL rand_ctrl[%0d]: got v=%b occ=%0d rdy=%b err=%b expected v=%b occ=%0d rdy=%b err=%b",
                         i, outValid, occupancy, inReady, selErr,
                         modelQ.size() > 0, modelQ.size(), modelReady, modelErr);
            end
            if (modelQ.size() > 0) begin
                total++;
                if (outData !== modelQ[0]) begin
                    bad++;
                    $display("[TB] FAIL rand_data[%0d]: got %h expected %h", i, outData, modelQ[0]);
                end
            end
        end
        applyStimulus(0, 0, 1, 0);
        cycle();
        cycle();
    endtask

    task automatic checkOutput();
        bit expErr;
        logic [VW-1:0] expData;
        expErr = 1'b0;
        for (int k = 0; k < VN; k++) vData[k*VW +: VW] = VW'(8'hA0 + k);
        for (int s = 0; s < 8; s++) begin
            vSel   = VS'(s);
            vValid = 1'b1;
            cycle();
            expData = (s < VN) ? VW'(8'hA0 + s) : 8'hEE;
            if (s >= VN) expErr = 1'b1;
            total++;
            if (vOutValid !== 1'b1 || vOutData !== expData || vSelErr !== expErr || vOccupancy !== 2'd1) begin
                bad++;
                $display("[TB] FAIL var_sel%0d: got v=%b d=%h err=%b occ=%0d expected v=1 d=%h err=%b occ=1",
                         s, vOutValid, vOutData, vSelErr, vOccupancy, expData, expErr);
            end
        end
        vValid = 1'b0;
        cycle();
    endtask

    initial begin
        test_reset();
        test_select_sweep();
        test_flush();
        test_out_of_range();
        test_back_to_back();
        test_async_reset();
        test_random();
        checkOutput();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
